// File: rtl/cpu_mem_responder.sv
// Word-addressed RAM that answers single-word REQ/ACK read/write requests from the
// fetch/execute sequencer, inserting WAIT_CYCLES wait states and flagging out-of-range addresses.
module cpu_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              ERR,
    output logic              BUSY
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("cpu_mem_responder: WAIT_CYCLES must be within 0..15");
        end
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $error("cpu_mem_responder: DEPTH must be within 1..2**ADDR_W");
        end
    endgenerate

    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oor_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              capture;
    logic              enter_resp;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_oor;
    logic              ram_wr_en;

    // With zero wait states the RAM read happens on the capture edge itself,
    // so the access path must look at the live request rather than the captured copy.
    always_comb begin
        acc_we   = we_q;
        acc_addr = addr_q;
        if (state_q == ST_IDLE) begin
            acc_we   = WE;
            acc_addr = ADDR;
        end
        acc_oor = (33'(acc_addr) >= DEPTH_EXT);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= WE;
                addr_q  <= ADDR;
                wdata_q <= WDATA;
                oor_q   <= acc_oor;
            end
            if (enter_resp && !acc_we) begin
                rdata_q <= acc_oor ? '0 : mem_q[acc_addr];
            end
        end
    end

    // The write commits on the edge leaving RESP; a reset on that edge abandons it.
    assign ram_wr_en = nRESET && (state_q == ST_RESP) && we_q && !oor_q;

    always_ff @(posedge CLK) begin
        if (ram_wr_en) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign RDATA = rdata_q;
    assign ACK   = (state_q == ST_RESP);
    assign ERR   = (state_q == ST_RESP) && oor_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: three instances (2 waits/200 deep, 0 waits/200 deep,
// 1 wait/256 deep) driven by a directed vector table, hand sequences and random traffic.
module tb_cpu_mem_responder;

    localparam int NU = 3;

    logic        clk;
    logic        nrst_s  [NU];
    logic        req_s   [NU];
    logic        we_s    [NU];
    logic [7:0]  addr_s  [NU];
    logic [15:0] wdata_s [NU];
    logic [15:0] rdata_s [NU];
    logic        ack_s   [NU];
    logic        err_s   [NU];
    logic        busy_s  [NU];

    int wc_u    [NU] = '{2, 0, 1};
    int depth_u [NU] = '{200, 200, 256};

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)) dut0 (
        .CLK(clk), .nRESET(nrst_s[0]), .REQ(req_s[0]), .WE(we_s[0]), .ADDR(addr_s[0]),
        .WDATA(wdata_s[0]), .RDATA(rdata_s[0]), .ACK(ack_s[0]), .ERR(err_s[0]), .BUSY(busy_s[0])
    );
    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(0)) dut1 (
        .CLK(clk), .nRESET(nrst_s[1]), .REQ(req_s[1]), .WE(we_s[1]), .ADDR(addr_s[1]),
        .WDATA(wdata_s[1]), .RDATA(rdata_s[1]), .ACK(ack_s[1]), .ERR(err_s[1]), .BUSY(busy_s[1])
    );
    cpu_mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(1)) dut2 (
        .CLK(clk), .nRESET(nrst_s[2]), .REQ(req_s[2]), .WE(we_s[2]), .ADDR(addr_s[2]),
        .WDATA(wdata_s[2]), .RDATA(rdata_s[2]), .ACK(ack_s[2]), .ERR(err_s[2]), .BUSY(busy_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image with per-word "known" flags and last read value.
    logic [15:0] mem_d   [NU][256];
    bit          mem_v   [NU][256];
    logic [15:0] last_rd [NU];
    bit          last_kn [NU];
    int          prev_cap  [NU];
    bit          prev_keep [NU];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic model(input int u, input bit w, input logic [7:0] a, input logic [15:0] d,
                         output bit e_err, output logic [15:0] e_rd, output bit known);
        bit oor;
        oor   = (int'(a) >= depth_u[u]);
        e_err = oor;
        if (w) begin
            e_rd  = last_rd[u];
            known = last_kn[u];
            if (!oor) begin
                mem_d[u][a] = d;
                mem_v[u][a] = 1'b1;
            end
        end else begin
            if (oor) begin
                e_rd  = 16'h0000;
                known = 1'b1;
            end else begin
                e_rd  = mem_d[u][a];
                known = mem_v[u][a];
            end
            last_rd[u] = e_rd;
            last_kn[u] = known;
        end
    endtask

    task automatic txn(input int u, input bit w, input logic [7:0] a, input logic [15:0] d,
                       input bit keep, input bit garble, input bit e_err,
                       input logic [15:0] e_rd, input bit chk_rd, input string tag);
        int k;
        int capc;
        req_s[u]   = 1'b1;
        we_s[u]    = w;
        addr_s[u]  = a;
        wdata_s[u] = d;
        @(posedge clk);
        capc = cyc;
        #1;
        if (prev_keep[u]) chk({tag, " spacing"}, 32'(capc - prev_cap[u]), 32'(wc_u[u] + 2));
        prev_cap[u]  = capc;
        prev_keep[u] = keep;
        if (garble) begin
            req_s[u]   = 1'b0;
            we_s[u]    = ~w;
            addr_s[u]  = ~a;
            wdata_s[u] = ~d;
        end
        k = 0;
        while (ack_s[u] !== 1'b1 && k <= 20) begin
            chk({tag, " busy_wait"}, 32'(busy_s[u]), 32'd1);
            chk({tag, " err_wait"}, 32'(err_s[u]), 32'd0);
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(wc_u[u]));
        chk({tag, " err_ack"}, 32'(err_s[u]), 32'(e_err));
        chk({tag, " busy_ack"}, 32'(busy_s[u]), 32'd1);
        if (chk_rd) chk({tag, " rdata_ack"}, 32'(rdata_s[u]), 32'(e_rd));
        $display("txn %s u=%0d we=%0d addr=%02h wdata=%04h lat=%0d err=%0b rdata=%04h",
                 tag, u, w, a, d, k, err_s[u], rdata_s[u]);
        if (!keep) req_s[u] = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " ack_idle"}, 32'(ack_s[u]), 32'd0);
        chk({tag, " err_idle"}, 32'(err_s[u]), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy_s[u]), 32'd0);
        if (chk_rd) chk({tag, " rdata_hold"}, 32'(rdata_s[u]), 32'(e_rd));
    endtask

    typedef struct {
        int          u;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wd;
        bit          keep;
        bit          garble;
        bit          err;
        logic [15:0] rd;
    } vec_t;

    function automatic vec_t v(int u, bit we, logic [7:0] a, logic [15:0] d,
                               bit keep, bit garble, bit err, logic [15:0] rd);
        vec_t r;
        r.u = u; r.we = we; r.addr = a; r.wd = d;
        r.keep = keep; r.garble = garble; r.err = err; r.rd = rd;
        return r;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        bit          e_err;
        logic [15:0] e_rd;
        bit          kn;

        for (int u = 0; u < NU; u++) begin
            nrst_s[u]  = 1'b0;
            req_s[u]   = 1'b1;
            we_s[u]    = 1'b1;
            addr_s[u]  = 8'h20;
            wdata_s[u] = 16'h5555;
            last_rd[u] = 16'h0000;
            last_kn[u] = 1'b1;
            prev_keep[u] = 1'b0;
            prev_cap[u]  = 0;
        end

        // Reset held two cycles with REQ asserted
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < NU; u++) begin
                chk("reset ack", 32'(ack_s[u]), 32'd0);
                chk("reset err", 32'(err_s[u]), 32'd0);
                chk("reset busy", 32'(busy_s[u]), 32'd0);
                chk("reset rdata", 32'(rdata_s[u]), 32'd0);
            end
        end
        for (int u = 0; u < NU; u++) nrst_s[u] = 1'b1;
        req_s[1] = 1'b0;
        req_s[2] = 1'b0;
        model(0, 1'b1, 8'h20, 16'h5555, e_err, e_rd, kn);
        txn(0, 1'b1, 8'h20, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, "rst_release");

        tbl.push_back(v(0, 1, 8'h05, 16'hBEEF, 0, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 8'h05, 16'h0000, 0, 0, 0, 16'hBEEF));
        tbl.push_back(v(0, 1, 8'h06, 16'h0001, 1, 0, 0, 16'hBEEF));
        tbl.push_back(v(0, 0, 8'h06, 16'h0000, 0, 0, 0, 16'h0001));
        tbl.push_back(v(0, 1, 8'hC8, 16'hAAAA, 0, 0, 1, 16'h0001));
        tbl.push_back(v(0, 0, 8'hC8, 16'h0000, 0, 0, 1, 16'h0000));
        tbl.push_back(v(0, 1, 8'hC7, 16'h1357, 0, 0, 0, 16'h0000));
        tbl.push_back(v(0, 0, 8'hC7, 16'h0000, 0, 0, 0, 16'h1357));
        tbl.push_back(v(0, 1, 8'h10, 16'h1010, 0, 0, 0, 16'h1357));
        tbl.push_back(v(0, 0, 8'h10, 16'h0000, 0, 1, 0, 16'h1010));
        tbl.push_back(v(0, 1, 8'hFF, 16'h2222, 0, 0, 1, 16'h1010));
        tbl.push_back(v(0, 0, 8'h20, 16'h0000, 0, 0, 0, 16'h5555));
        tbl.push_back(v(1, 1, 8'h00, 16'h1234, 1, 0, 0, 16'h0000));
        tbl.push_back(v(1, 0, 8'h00, 16'h0000, 1, 0, 0, 16'h1234));
        tbl.push_back(v(1, 0, 8'hC8, 16'h0000, 0, 0, 1, 16'h0000));
        tbl.push_back(v(1, 1, 8'hC7, 16'h7777, 0, 1, 0, 16'h0000));
        tbl.push_back(v(1, 0, 8'hC7, 16'h0000, 0, 0, 0, 16'h7777));
        tbl.push_back(v(2, 1, 8'hFF, 16'hABCD, 0, 0, 0, 16'h0000));
        tbl.push_back(v(2, 0, 8'hFF, 16'h0000, 0, 0, 0, 16'hABCD));
        tbl.push_back(v(2, 1, 8'h00, 16'h0F0F, 0, 0, 0, 16'hABCD));

        foreach (tbl[i]) begin
            model(tbl[i].u, tbl[i].we, tbl[i].addr, tbl[i].wd, e_err, e_rd, kn);
            txn(tbl[i].u, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].keep, tbl[i].garble,
                tbl[i].err, tbl[i].rd, 1'b1, $sformatf("vec%0d", i));
        end

        // Reset pulsed during the wait states of a write: no ACK, no RAM update
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 8'h10; wdata_s[0] = 16'h9999;
        @(posedge clk);
        #1;
        chk("abort busy_wait", 32'(busy_s[0]), 32'd1);
        nrst_s[0] = 1'b0;
        req_s[0]  = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy_rst", 32'(busy_s[0]), 32'd0);
        chk("abort rdata_rst", 32'(rdata_s[0]), 32'd0);
        nrst_s[0]    = 1'b1;
        last_rd[0]   = 16'h0000;
        last_kn[0]   = 1'b1;
        prev_keep[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("abort no_ack", 32'(ack_s[0]), 32'd0);
            chk("abort idle", 32'(busy_s[0]), 32'd0);
        end
        model(0, 1'b0, 8'h10, 16'h0000, e_err, e_rd, kn);
        txn(0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b1, "abort_readback");

        // Random traffic checked against the reference model
        for (int u = 0; u < NU; u++) begin
            for (int n = 0; n < 50; n++) begin
                bit          w;
                bit          keep;
                bit          garble;
                logic [7:0]  a;
                logic [15:0] d;
                int          sel;
                sel = int'($urandom_range(0, 9));
                if (sel < 6)      a = 8'($urandom_range(0, 31));
                else if (sel < 8) a = 8'((depth_u[u] - 2 + int'($urandom_range(0, 3))) % 256);
                else              a = 8'($urandom_range(0, 255));
                w      = 1'($urandom_range(0, 1));
                d      = 16'($urandom);
                keep   = ($urandom_range(0, 3) == 0) && (n != 49);
                garble = !keep && ($urandom_range(0, 2) == 0);
                model(u, w, a, d, e_err, e_rd, kn);
                txn(u, w, a, d, keep, garble, e_err, e_rd, kn, $sformatf("rnd%0d_%0d", u, n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
